// File: rtl/vga_pixel_fifo.sv
// Pixel FIFO feeding the VGA timing controller: 30-bit RGB storage, 1-cycle registered
// read, ball overlay substitution, and sticky overflow/underflow debug status.
module vga_pixel_fifo #(
    parameter int          DEPTH      = 1024,
    parameter int          AW         = 10,
    parameter logic [29:0] BALL_COLOR = 30'h3FF00000,
    parameter logic [29:0] FILL_COLOR = 30'h0
) (
    input  logic          iCLK,
    input  logic          iRST_N,
    input  logic [29:0]   iWR_DATA,
    input  logic          iWR_EN,
    output logic          oFULL,
    input  logic          iRequest,
    input  logic          iIsBall,
    input  logic          iFLUSH,
    input  logic          iCLR_STATUS,
    output logic [9:0]    oRed,
    output logic [9:0]    oGreen,
    output logic [9:0]    oBlue,
    output logic [AW:0]   oUsedw,
    output logic          oEMPTY,
    output logic          oOverflow,
    output logic          oUnderflow,
    output logic [15:0]   oUnderCnt
);

    logic [29:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic [29:0]   r_pix;
    logic          r_ovf;
    logic          r_unf;
    logic [15:0]   r_ucnt;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;
    logic w_wr;
    logic w_rd;
    logic w_drop;
    logic w_under;

    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = iRequest && !w_empty;
    assign w_push  = iWR_EN && (!w_full || w_pop);

    // A flush cycle suppresses every FIFO event, including the status side effects.
    assign w_wr    = w_push && !iFLUSH;
    assign w_rd    = w_pop && !iFLUSH;
    assign w_drop  = iWR_EN && w_full && !w_pop && !iFLUSH;
    assign w_under = iRequest && w_empty && !iFLUSH;

    always_ff @(posedge iCLK) begin
        if (w_wr) begin
            r_mem[r_wp] <= iWR_DATA;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else if (iFLUSH) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop)  r_rp <= r_rp + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    // No write-to-read bypass: an underflow always outputs the fill/ball colour.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_pix <= '0;
        end else if (w_rd) begin
            r_pix <= iIsBall ? BALL_COLOR : r_mem[r_rp];
        end else if (w_under) begin
            r_pix <= iIsBall ? BALL_COLOR : FILL_COLOR;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_ucnt <= '0;
        end else begin
            r_ovf <= w_drop  || (r_ovf && !iCLR_STATUS);
            r_unf <= w_under || (r_unf && !iCLR_STATUS);
            if (w_under) begin
                if (iCLR_STATUS)            r_ucnt <= 16'd1;
                else if (r_ucnt != 16'hFFFF) r_ucnt <= r_ucnt + 1'b1;
            end else if (iCLR_STATUS) begin
                r_ucnt <= '0;
            end
        end
    end

    assign oRed       = r_pix[29:20];
    assign oGreen     = r_pix[19:10];
    assign oBlue      = r_pix[9:0];
    assign oUsedw     = r_count;
    assign oFULL      = w_full;
    assign oEMPTY     = w_empty;
    assign oOverflow  = r_ovf;
    assign oUnderflow = r_unf;
    assign oUnderCnt  = r_ucnt;

endmodule
